prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Writer side of the CPU program ROM: receives a framed byte stream (e.g. from a UART
//  receiver) and writes 16-bit instruction words into the 256x16 program memory that the
//  CPU FETCH state reads. Holds the CPU stalled via cpu_hold while a load is in progress.
//  Allows programs to be replaced at run time instead of only by $readmemh at elaboration.
// PARAMETERS
//  TIMEOUT_CYC  1000  cycles with no accepted byte mid-frame before the frame is aborted
//  BOOT_HOLD    0     reset value of cpu_hold (1 = CPU stays stalled until first good load)
// PORTS
//  clk        in   1   single clock, all state on posedge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   in_data holds a byte
//  in_data    in   8   stream byte
//  in_ready   out  1   byte accepted when in_valid && in_ready
//  mem_we     out  1   program-memory write strobe, one cycle per word
//  mem_addr   out  8   word address (= CPU pc)
//  mem_wdata  out  16  instruction word {hi,lo}
//  cpu_hold   out  1   CPU must not advance pc while high
//  done       out  1   one-cycle pulse: frame completed and accepted
//  err        out  1   one-cycle pulse: frame aborted (checksum or timeout)
//  last_ok    out  1   status of most recent finished frame (1 = good)
// BEHAVIOUR
//  Reset: in_ready=0 during reset, 1 from first clock after release; mem_we=0, mem_addr=0,
//   mem_wdata=0, done=0, err=0, last_ok=0, cpu_hold=BOOT_HOLD, state=IDLE.
//  Frame: A5, BASE, CNT, then CNT words (hi byte, lo byte), then CSUM. CNT=0 means 256 words.
//  in_ready=1 in every state out of reset; loader never back-pressures.
//  States: IDLE -> BASE -> CNT -> HI -> LO -> (HI | CSUM) -> IDLE.
//   IDLE: bytes other than 8'hA5 are discarded; A5 moves to BASE and sets cpu_hold=1.
//   LO: on accept, next cycle mem_we=1, mem_addr=BASE+index (mod 256), mem_wdata={hi,lo}.
//   After the CNT-th word -> CSUM, else -> HI.
//  Checksum: 8-bit sum of BASE, CNT, all data bytes and CSUM must equal 8'h00.
//   Match: cycle after CSUM accept done=1, last_ok=1, cpu_hold=0, state IDLE.
//   Mismatch: err=1, last_ok=0, cpu_hold stays 1; words already written are not undone.
//  Timeout: in any state except IDLE, counter clears on each accepted byte; on reaching
//   TIMEOUT_CYC idle cycles -> err=1, last_ok=0, cpu_hold stays 1, state IDLE.
//  Address wrap: BASE+index wraps mod 256 (BASE=FF, CNT=2 writes FF then 00).
//  Simultaneous: a header byte arriving in the done/err cycle is accepted (state is IDLE).
//  Reset mid-frame: partial frame dropped, all outputs to reset values; memory keeps writes.
// CONFIGURATION
//  PROG_LOADER_CKSUM_EN defined: CSUM byte expected and checked as above.
//  Not defined: no CSUM state; done=1, last_ok=1, cpu_hold=0 in the same cycle as the last
//   mem_we; err only from timeout.
// STRUCTURE
//  Package prog_loader_pkg: state enum {IDLE,BASE,CNT,HI,LO,CSUM}, HDR_BYTE=8'hA5,
//   INST_W=16, PC_W=8 (shared with CPU for memory sizing).
//  Sub-module prog_loader_timer: idle-cycle counter with clear/enable, expired pulse.
// TESTING
//  1 (CKSUM_EN) A5 10 02 12 34 AB CD 30 -> mem[10]=1234, mem[11]=ABCD, done 1 cycle, cpu_hold 0.
//  2 same frame with CSUM=31 -> both writes occur, err pulse, no done, cpu_hold 1, last_ok 0.
//  3 BASE=FF CNT=02 -> writes at addr FF then 00; done.
//  4 CNT=00 with 256 words -> exactly 256 mem_we pulses, addr BASE..BASE+255 mod 256.
//  5 A5 10 01 12 then silence -> err exactly TIMEOUT_CYC cycles after 12 accepted, no mem_we.
//  6 bytes 00 FF 5A then frame of test 1 -> garbage ignored, same result; rst_n low after
//    BASE byte -> outputs reset, following good frame completes with done.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader and the CPU program memory.
package prog_loader_pkg;

  localparam int unsigned INST_W = 16;
  localparam int unsigned PC_W   = 8;
  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BASE,
    ST_CNT,
    ST_HI,
    ST_LO,
    ST_CSUM
  } state_e;

  // One program-memory write: word address and instruction word.
  typedef struct packed {
    logic [PC_W-1:0]   addr;
    logic [INST_W-1:0] data;
  } mem_wr_t;

  // Word address for the idx-th word of a frame; wraps at the top of memory.
  function automatic logic [PC_W-1:0] word_addr(input logic [PC_W-1:0] base,
                                                input logic [PC_W-1:0] idx);
    return PC_W'(base + idx);
  endfunction

endpackage

// File: rtl/prog_loader_timer.sv
// Idle-cycle watchdog for the loader. Counts enabled cycles since the last clear and
// raises a one-cycle registered pulse one cycle ahead of the limit, so that the
// consumer acting on it lands its abort exactly TIMEOUT_CYC cycles after the clear.
// TIMEOUT_CYC must be at least 2.
module prog_loader_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] FIRE_AT = CNT_W'(TIMEOUT_CYC - 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exp_q, exp_d;

  // Next count and early-warning pulse; clear wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    exp_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = CNT_W'(cnt_q + 1'b1);
      exp_d = (cnt_q == FIRE_AT);
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      exp_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
    end
  end

  assign expired_o = exp_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: parses framed byte stream A5, BASE, CNT, CNT x {HI, LO} [, CSUM]
// and writes 16-bit words into the CPU program memory while stalling the CPU.
// Build option: define PROG_LOADER_CKSUM_EN to expect and verify the trailing CSUM byte
// (8-bit sum of BASE, CNT, data bytes and CSUM must be zero).
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1000,
  parameter logic        BOOT_HOLD   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [BYTE_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [PC_W-1:0]   mem_addr_o,
  output logic [INST_W-1:0] mem_wdata_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o,
  output logic              last_ok_o
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   base_q, base_d;
  logic [PC_W-1:0]   num_q, num_d;
  logic [PC_W-1:0]   idx_q, idx_d;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [BYTE_W-1:0] sum_q, sum_d;
  mem_wr_t           wr_q, wr_d;
  logic              mem_we_q, mem_we_d;
  logic              in_ready_q;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              last_ok_q, last_ok_d;

  logic              accept;
  logic              expired;
  logic              last_word;

  assign accept    = in_valid_i && in_ready_q;
  // CNT=0 encodes 256 words, which falls out of comparing against CNT-1 mod 256.
  assign last_word = (idx_q == PC_W'(num_q - 8'd1));

  // Watchdog restarts on every accepted byte and stays cleared while idle.
  prog_loader_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (accept || (state_q == ST_IDLE)),
    .en_i      (1'b1),
    .expired_o (expired)
  );

  // Frame parser: next state, datapath updates and registered output strobes.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    idx_d     = idx_q;
    hi_d      = hi_q;
    sum_d     = sum_q;
    wr_d      = wr_q;
    mem_we_d  = 1'b0;
    hold_d    = hold_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    last_ok_d = last_ok_q;

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (in_data_i == HDR_BYTE) begin
            state_d = ST_BASE;
            hold_d  = 1'b1;
          end
        end
        ST_BASE: begin
          base_d  = in_data_i;
          sum_d   = in_data_i;
          idx_d   = '0;
          state_d = ST_CNT;
        end
        ST_CNT: begin
          num_d   = in_data_i;
          sum_d   = BYTE_W'(sum_q + in_data_i);
          state_d = ST_HI;
        end
        ST_HI: begin
          hi_d    = in_data_i;
          sum_d   = BYTE_W'(sum_q + in_data_i);
          state_d = ST_LO;
        end
        ST_LO: begin
          sum_d     = BYTE_W'(sum_q + in_data_i);
          mem_we_d  = 1'b1;
          wr_d.addr = word_addr(base_q, idx_q);
          wr_d.data = {hi_q, in_data_i};
          if (last_word) begin
`ifdef PROG_LOADER_CKSUM_EN
            state_d   = ST_CSUM;
`else
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            last_ok_d = 1'b1;
            hold_d    = 1'b0;
`endif
          end else begin
            idx_d   = PC_W'(idx_q + 1'b1);
            state_d = ST_HI;
          end
        end
        ST_CSUM: begin
          state_d = ST_IDLE;
          if (BYTE_W'(sum_q + in_data_i) == '0) begin
            done_d    = 1'b1;
            last_ok_d = 1'b1;
            hold_d    = 1'b0;
          end else begin
            err_d     = 1'b1;
            last_ok_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (expired && (state_q != ST_IDLE)) begin
      // Stalled mid-frame: drop it and keep the CPU held.
      state_d   = ST_IDLE;
      err_d     = 1'b1;
      last_ok_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      idx_q      <= '0;
      hi_q       <= '0;
      sum_q      <= '0;
      wr_q       <= '0;
      mem_we_q   <= 1'b0;
      in_ready_q <= 1'b0;
      hold_q     <= BOOT_HOLD;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      last_ok_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      idx_q      <= idx_d;
      hi_q       <= hi_d;
      sum_q      <= sum_d;
      wr_q       <= wr_d;
      mem_we_q   <= mem_we_d;
      in_ready_q <= 1'b1;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      last_ok_q  <= last_ok_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = wr_q.addr;
  assign mem_wdata_o = wr_q.data;
  assign cpu_hold_o  = hold_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign last_ok_o   = last_ok_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad frames, address wrap, 256-word frame,
// timeout, garbage before header and reset mid-frame.
module tb_prog_loader;

  localparam int unsigned TIMEOUT = 1000;
`ifdef PROG_LOADER_CKSUM_EN
  localparam int DONE_LAG = 1;
`else
  localparam int DONE_LAG = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, cpu_hold, done, err, last_ok;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;

  always #5 clk = ~clk;

  prog_loader #(
    .TIMEOUT_CYC (TIMEOUT),
    .BOOT_HOLD   (1'b0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .cpu_hold_o  (cpu_hold),
    .done_o      (done),
    .err_o       (err),
    .last_ok_o   (last_ok)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  int last_we_cyc = 0, done_cyc = 0, err_cyc = 0;
  logic [15:0] mem [256];
  logic [7:0]  addr_log [$];
  logic [15:0] wbuf [256];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model and pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        mem[mem_addr] = mem_wdata;
        addr_log.push_back(mem_addr);
        wr_cnt      = wr_cnt + 1;
        last_we_cyc = cyc;
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (err) begin
        err_cnt = err_cnt + 1;
        err_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  // Frame from wbuf; adj is added to the correct checksum byte to corrupt it.
  task automatic send_frame(input logic [7:0] base, input logic [7:0] cnt,
                            input logic [7:0] adj);
    int n;
    logic [7:0] sum;
    n   = (cnt == 8'h00) ? 256 : int'(cnt);
    sum = 8'(base + cnt);
    send(8'hA5);
    send(base);
    send(cnt);
    for (int i = 0; i < n; i++) begin
      send(wbuf[i][15:8]);
      send(wbuf[i][7:0]);
      sum = 8'(sum + wbuf[i][15:8] + wbuf[i][7:0]);
    end
`ifdef PROG_LOADER_CKSUM_EN
    send(8'(8'h00 - sum + adj));
`else
    if (adj != 8'h00) sum = 8'h00;
`endif
  endtask

  // Test-1 frame with literal bytes.
  task automatic send_t1(input logic [7:0] csum);
    send(8'hA5); send(8'h10); send(8'h02);
    send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
`ifdef PROG_LOADER_CKSUM_EN
    send(csum);
`else
    if (csum == 8'h00) in_data = 8'h00;
`endif
  endtask

  int w0, d0, e0, l0, badcells;

  initial begin
    // Reset values while held in reset.
    @(negedge clk);
    check("rst_ready",   32'(in_ready), 32'd0);
    check("rst_hold",    32'(cpu_hold), 32'd0);
    check("rst_we",      32'(mem_we),   32'd0);
    check("rst_flags",   32'({done, err, last_ok}), 32'd0);
    check("rst_addr",    32'(mem_addr), 32'd0);
    check("rst_wdata",   32'(mem_wdata), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_pre",   32'(in_ready), 32'd0);
    idle(1);
    check("ready_post",  32'(in_ready), 32'd1);

    // Test 1: good two-word frame.
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    send_t1(8'h30);
    idle(3);
    check("t1_writes",   32'(wr_cnt - w0), 32'd2);
    check("t1_mem10",    32'(mem[8'h10]), 32'h1234);
    check("t1_mem11",    32'(mem[8'h11]), 32'hABCD);
    check("t1_done",     32'(done_cnt - d0), 32'd1);
    check("t1_err",      32'(err_cnt - e0), 32'd0);
    check("t1_hold",     32'(cpu_hold), 32'd0);
    check("t1_last_ok",  32'(last_ok), 32'd1);
    check("t1_done_lag", 32'(done_cyc - last_we_cyc), 32'(DONE_LAG));

`ifdef PROG_LOADER_CKSUM_EN
    // Test 2: same frame with a bad checksum.
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    send_t1(8'h31);
    idle(3);
    check("t2_writes",   32'(wr_cnt - w0), 32'd2);
    check("t2_err",      32'(err_cnt - e0), 32'd1);
    check("t2_done",     32'(done_cnt - d0), 32'd0);
    check("t2_hold",     32'(cpu_hold), 32'd1);
    check("t2_last_ok",  32'(last_ok), 32'd0);
`endif

    // Test 3: address wrap at the top of memory.
    w0 = wr_cnt; d0 = done_cnt; l0 = addr_log.size();
    wbuf[0] = 16'h1111;
    wbuf[1] = 16'h2222;
    send_frame(8'hFF, 8'h02, 8'h00);
    idle(3);
    check("t3_writes",   32'(wr_cnt - w0), 32'd2);
    check("t3_addr0",    32'(addr_log[l0]), 32'hFF);
    check("t3_addr1",    32'(addr_log[l0 + 1]), 32'h00);
    check("t3_memFF",    32'(mem[8'hFF]), 32'h1111);
    check("t3_mem00",    32'(mem[8'h00]), 32'h2222);
    check("t3_done",     32'(done_cnt - d0), 32'd1);

    // Test 5: header then silence mid-frame.
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    send(8'hA5); send(8'h10); send(8'h01); send(8'h12);
    l0 = acc_cyc;
    for (int k = 0; k < int'(TIMEOUT) + 20 && err_cnt == e0; k++) idle(1);
    check("t5_err",      32'(err_cnt - e0), 32'd1);
    check("t5_err_cyc",  32'(err_cyc - l0), 32'(TIMEOUT));
    check("t5_writes",   32'(wr_cnt - w0), 32'd0);
    check("t5_done",     32'(done_cnt - d0), 32'd0);
    check("t5_hold",     32'(cpu_hold), 32'd1);
    check("t5_last_ok",  32'(last_ok), 32'd0);

    // Test 4: CNT=0 means 256 words.
    w0 = wr_cnt; d0 = done_cnt; l0 = addr_log.size();
    for (int i = 0; i < 256; i++) wbuf[i] = {8'(i), ~8'(i)};
    send_frame(8'h40, 8'h00, 8'h00);
    idle(3);
    badcells = 0;
    for (int i = 0; i < 256; i++)
      if (mem[8'(8'h40 + i)] !== {8'(i), ~8'(i)}) badcells++;
    check("t4_writes",   32'(wr_cnt - w0), 32'd256);
    check("t4_cells",    32'(badcells), 32'd0);
    check("t4_first",    32'(addr_log[l0]), 32'h40);
    check("t4_last",     32'(addr_log[l0 + 255]), 32'h3F);
    check("t4_done",     32'(done_cnt - d0), 32'd1);
    check("t4_hold",     32'(cpu_hold), 32'd0);

    // Test 6: garbage before the header is ignored.
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    send(8'h00); send(8'hFF); send(8'h5A);
    send_t1(8'h30);
    idle(3);
    check("t6_writes",   32'(wr_cnt - w0), 32'd2);
    check("t6_mem10",    32'(mem[8'h10]), 32'h1234);
    check("t6_mem11",    32'(mem[8'h11]), 32'hABCD);
    check("t6_done",     32'(done_cnt - d0), 32'd1);
    check("t6_err",      32'(err_cnt - e0), 32'd0);

    // Reset after BASE byte, then a fresh good frame.
    send(8'hA5); send(8'h10);
    check("mid_hold_pre", 32'(cpu_hold), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_ready",   32'(in_ready), 32'd0);
    check("mid_hold",    32'(cpu_hold), 32'd0);
    check("mid_last_ok", 32'(last_ok), 32'd0);
    check("mid_addr",    32'(mem_addr), 32'd0);
    check("mid_wdata",   32'(mem_wdata), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    w0 = wr_cnt; d0 = done_cnt;
    wbuf[0] = 16'hCAFE;
    send_frame(8'h20, 8'h01, 8'h00);
    idle(3);
    check("post_writes", 32'(wr_cnt - w0), 32'd1);
    check("post_mem20",  32'(mem[8'h20]), 32'hCAFE);
    check("post_done",   32'(done_cnt - d0), 32'd1);
    check("post_last_ok", 32'(last_ok), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
